word_serializer: RTL and testbench

//   Parametrised wide-word to narrow-chunk serializer, the successor of the fixed 128->8 splitter.

---
 rtl/word_serializer.sv | 121 ++++++++++++
 tb/tb_word_serializer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/word_serializer.sv
// Wide-word to narrow-chunk serializer with valid/ready on both sides,
// a per-word chunk count and selectable chunk order.
module word_serializer #(
    parameter int unsigned IN_W      = 128,
    parameter int unsigned OUT_W     = 8,
    parameter bit          MSB_FIRST = 1'b0,
    localparam int unsigned NCHUNK   = IN_W / OUT_W,
    localparam int unsigned CW       = $clog2(NCHUNK + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  in_data,
    input  logic [CW-1:0]    in_len,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    if (IN_W % OUT_W != 0) begin : g_cfg_err
        $fatal(1, "word_serializer: IN_W must be a multiple of OUT_W");
    end

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    len_q, len_d;
    logic [IN_W-1:0]  shreg_q, shreg_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             done_q, done_d;
    logic [CW-1:0]    eff_len_c;
    logic             last_c;

    // The shift register always holds the not-yet-sent chunks aligned so the
    // next one sits at the head; this avoids a variable-index mux.
    function automatic logic [OUT_W-1:0] head(input logic [IN_W-1:0] w);
        if (MSB_FIRST) return w[IN_W-1 -: OUT_W];
        else           return w[OUT_W-1:0];
    endfunction

    function automatic logic [IN_W-1:0] advance(input logic [IN_W-1:0] w);
        if (MSB_FIRST) return w << OUT_W;
        else           return w >> OUT_W;
    endfunction

    assign eff_len_c = ((in_len == '0) || (in_len > CW'(NCHUNK))) ? CW'(NCHUNK) : in_len;
    assign last_c    = (idx_q == (len_q - CW'(1)));

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            len_q       <= '0;
            shreg_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            shreg_q     <= shreg_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        len_d       = len_q;
        shreg_d     = shreg_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d     = SHIFT;
                    idx_d       = '0;
                    len_d       = eff_len_c;
                    out_data_d  = head(in_data);
                    shreg_d     = advance(in_data);
                    out_valid_d = 1'b1;
                end
            end
            SHIFT: begin
                if (out_valid_q && out_ready) begin
                    if (last_c) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        idx_d      = idx_q + CW'(1);
                        out_data_d = head(shreg_q);
                        shreg_d    = advance(shreg_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == SHIFT);
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_valid_q & last_c;
    assign done      = done_q;

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer: default 128->8 LSB-first instance and
// a 32->8 MSB-first instance sharing clock and reset.
module tb_word_serializer;

    logic clk;
    logic rst_n;

    logic [127:0] in_data_a;
    logic [4:0]   in_len_a;
    logic         in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_last_a, busy_a, done_a;
    logic [7:0]   out_data_a;

    logic [31:0]  in_data_b;
    logic [2:0]   in_len_b;
    logic         in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_last_b, busy_b, done_b;
    logic [7:0]   out_data_b;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [127:0] W_T2  = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [127:0] W_NEW = 128'h1F1E1D1C_1B1A1918_17161514_13121110;

    word_serializer u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data_a), .in_len(in_len_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .out_last(out_last_a), .busy(busy_a), .done(done_a)
    );

    word_serializer #(.IN_W(32), .OUT_W(8), .MSB_FIRST(1'b1)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data_b), .in_len(in_len_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_last(out_last_b), .busy(busy_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [127:0] w, input logic [4:0] len);
        in_data_a  = w;
        in_len_a   = len;
        in_valid_a = 1'b1;
        check("a_in_ready_before_accept", 128'(in_ready_a), 128'd1);
        tick();
        in_valid_a = 1'b0;
        in_data_a  = '0;
        check("a_busy_after_accept", 128'(busy_a), 128'd1);
        check("a_in_ready_busy", 128'(in_ready_a), 128'd0);
    endtask

    // Drain n chunks of w from instance A; rnd selects a pseudo-random out_ready.
    task automatic recv_a(input logic [127:0] w, input int n, input bit rnd);
        int         k = 0;
        int         cyc = 0;
        bit         stalled = 1'b0;
        logic [7:0] held = '0;
        logic [7:0] lf = 8'h5A;
        logic [7:0] exp_chunk;
        while (k < n && cyc < 300) begin
            if (rnd) begin
                lf          = {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
                out_ready_a = lf[0];
            end else begin
                out_ready_a = 1'b1;
            end
            exp_chunk = w[k*8 +: 8];
            check("a_out_valid", 128'(out_valid_a), 128'd1);
            check("a_out_data", 128'(out_data_a), 128'(exp_chunk));
            check("a_out_last", 128'(out_last_a), 128'(k == n - 1));
            if (stalled) check("a_stall_hold", 128'(out_data_a), 128'(held));
            if (out_ready_a) begin
                k++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held    = out_data_a;
            end
            tick();
            cyc++;
        end
        if (k < n) check("a_recv_timeout", 128'(k), 128'(n));
        out_ready_a = 1'b0;
        check("a_done_pulse", 128'(done_a), 128'd1);
        check("a_out_valid_after_last", 128'(out_valid_a), 128'd0);
        check("a_idle_in_ready", 128'(in_ready_a), 128'd1);
        tick();
        check("a_done_one_cycle", 128'(done_a), 128'd0);
    endtask

    initial begin
        logic [7:0] exp_b [4];
        exp_b[0] = 8'hAA; exp_b[1] = 8'hBB; exp_b[2] = 8'hCC; exp_b[3] = 8'hDD;

        rst_n = 1'b0;
        in_data_a = '0; in_len_a = '0; in_valid_a = 1'b0; out_ready_a = 1'b0;
        in_data_b = '0; in_len_b = '0; in_valid_b = 1'b0; out_ready_b = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        check("rst_out_data", 128'(out_data_a), 128'd0);
        check("rst_out_valid", 128'(out_valid_a), 128'd0);
        check("rst_done", 128'(done_a), 128'd0);
        check("rst_in_ready", 128'(in_ready_a), 128'd1);
        check("rst_busy", 128'(busy_a), 128'd0);

        // T2: default length, always ready
        send_a(W_T2, 5'd0);
        recv_a(W_T2, 16, 1'b0);

        // T3: pseudo-random backpressure
        send_a(W_T2, 5'd0);
        recv_a(W_T2, 16, 1'b1);

        // T4: short and oversize lengths
        send_a(W_T2, 5'd3);
        recv_a(W_T2, 3, 1'b0);
        send_a(W_T2, 5'd20);
        recv_a(W_T2, 16, 1'b0);

        // T1/T6: reset after 5 chunks, then a fresh word starts at chunk0
        send_a(W_T2, 5'd0);
        out_ready_a = 1'b1;
        repeat (5) tick();
        check("t6_mid_chunk", 128'(out_data_a), 128'h05);
        #2;
        rst_n = 1'b0;
        #1;
        check("t1_async_out_valid", 128'(out_valid_a), 128'd0);
        check("t1_async_done", 128'(done_a), 128'd0);
        check("t1_async_in_ready", 128'(in_ready_a), 128'd1);
        out_ready_a = 1'b0;
        #13;
        rst_n = 1'b1;
        tick();
        check("t1_out_data_zero", 128'(out_data_a), 128'd0);
        check("t1_out_valid_zero", 128'(out_valid_a), 128'd0);
        send_a(W_NEW, 5'd4);
        recv_a(W_NEW, 4, 1'b0);

        // T5: MSB-first 32->8, input ignored while busy
        in_data_b  = 32'hAABBCCDD;
        in_len_b   = 3'd0;
        in_valid_b = 1'b1;
        tick();
        in_valid_b = 1'b0;
        check("b_busy", 128'(busy_b), 128'd1);
        for (int k = 0; k < 4; k++) begin
            out_ready_b = 1'b1;
            if (k == 1) begin
                in_valid_b = 1'b1;
                in_data_b  = 32'h11223344;
                in_len_b   = 3'd1;
            end else begin
                in_valid_b = 1'b0;
            end
            check("b_out_valid", 128'(out_valid_b), 128'd1);
            check("b_out_data", 128'(out_data_b), 128'(exp_b[k]));
            check("b_out_last", 128'(out_last_b), 128'(k == 3));
            tick();
        end
        in_valid_b  = 1'b0;
        out_ready_b = 1'b0;
        check("b_done", 128'(done_b), 128'd1);
        check("b_out_valid_after", 128'(out_valid_b), 128'd0);
        check("b_in_ready_after", 128'(in_ready_b), 128'd1);
        tick();
        check("b_done_clear", 128'(done_b), 128'd0);
        check("b_no_stray_accept", 128'(busy_b), 128'd0);

        // Second MSB-first word with in_len=2
        in_data_b  = 32'h11223344;
        in_len_b   = 3'd2;
        in_valid_b = 1'b1;
        tick();
        in_valid_b  = 1'b0;
        out_ready_b = 1'b1;
        check("b2_chunk0", 128'(out_data_b), 128'h11);
        check("b2_last0", 128'(out_last_b), 128'd0);
        tick();
        check("b2_chunk1", 128'(out_data_b), 128'h22);
        check("b2_last1", 128'(out_last_b), 128'd1);
        tick();
        check("b2_done", 128'(done_b), 128'd1);
        out_ready_b = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
